// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divide controller.
// The optional edge counter is controlled by CLK_DIV_CTRL_EDGE_CNT_EN in clk_div_ctrl.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int EDGE_CNT_W = 16;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] DIV_ZERO = 2'd1;

endpackage

// File: rtl/clk_div_core.sv
// Counter/toggle generator: each phase of clk_div lasts active_div clock cycles.
// boundary marks the edge on which clk_div falls (end of a full period).
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stop_at_low,
    input  logic [DIV_W-1:0] active_div,
    output logic             clk_div,
    output logic             div_tick,
    output logic             boundary
);

    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             clk_div_reg, clk_div_next;
    logic             tick_reg, tick_next;
    logic             last;

    assign last = (cnt_reg == active_div - DIV_W'(1));

    always_comb begin
        cnt_next     = '0;
        clk_div_next = 1'b0;
        tick_next    = 1'b0;
        // A stop request during the low phase parks the output low without rising.
        if (enable && !(stop_at_low && !clk_div_reg)) begin
            if (last) begin
                clk_div_next = !clk_div_reg;
                tick_next    = !clk_div_reg;
            end else begin
                cnt_next     = cnt_reg + DIV_W'(1);
                clk_div_next = clk_div_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            clk_div_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            clk_div_reg <= clk_div_next;
            tick_reg    <= tick_next;
        end
    end

    assign clk_div  = clk_div_reg;
    assign div_tick = tick_reg;
    assign boundary = enable && clk_div_reg && last;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the divided clock: FSM, ratio handshake and edge counter.
// Define CLK_DIV_CTRL_EDGE_CNT_EN to build the clk_div rising-edge counter.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  cfg_valid,
    input  logic [DIV_W-1:0]      cfg_div,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic                  clk_div,
    output logic                  div_tick,
    output logic                  busy,
    output logic [DIV_W-1:0]      active_div,
    output logic [EDGE_CNT_W-1:0] edge_cnt
);

    state_t           state_reg, state_next;
    logic             pend_reg;
    logic [DIV_W-1:0] pend_div_reg;
    logic [DIV_W-1:0] active_div_reg;
    logic             cfg_err_reg;
    logic             boundary;
    logic             core_clk_div;
    logic             core_tick;
    logic [1:0]       cfg_code;
    logic             take;
    logic             apply;

    assign cfg_code = (cfg_div == '0) ? DIV_ZERO : ERR_NONE;
    assign take     = cfg_valid && !pend_reg;
    // Ratio changes only land when the divider is idle or at a period boundary.
    assign apply    = pend_reg && ((state_reg == IDLE) || boundary);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (run) state_next = RUN;
            end
            RUN: begin
                if (!run) begin
                    if (!core_clk_div || boundary) state_next = IDLE;
                    else                           state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (boundary) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg       <= 1'b0;
            pend_div_reg   <= '0;
            active_div_reg <= DIV_W'(DEFAULT_DIV);
            cfg_err_reg    <= 1'b0;
        end else begin
            cfg_err_reg <= take && (cfg_code == DIV_ZERO);
            if (apply) begin
                active_div_reg <= pend_div_reg;
                pend_reg       <= 1'b0;
            end
            if (take && (cfg_code == ERR_NONE)) begin
                pend_reg     <= 1'b1;
                pend_div_reg <= cfg_div;
            end
        end
    end

    clk_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state_reg != IDLE),
        .stop_at_low((state_reg == RUN) && !run),
        .active_div (active_div_reg),
        .clk_div    (core_clk_div),
        .div_tick   (core_tick),
        .boundary   (boundary)
    );

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] edge_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         edge_cnt_reg <= '0;
        else if (core_tick) edge_cnt_reg <= edge_cnt_reg + EDGE_CNT_W'(1);
    end

    assign edge_cnt = edge_cnt_reg;
`else
    assign edge_cnt = '0;
`endif

    assign cfg_ready  = !pend_reg;
    assign cfg_err    = cfg_err_reg;
    assign clk_div    = core_clk_div;
    assign div_tick   = core_tick;
    assign busy       = (state_reg != IDLE);
    assign active_div = active_div_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: phase-countdown reference model plus directed and random stimulus.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        cfg_valid;
    logic [7:0]  cfg_div;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_div;
    logic        div_tick;
    logic        busy;
    logic [7:0]  active_div;
    logic [15:0] edge_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_W      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .div_tick  (div_tick),
        .busy      (busy),
        .active_div(active_div),
        .edge_cnt  (edge_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the remaining cycles of the current phase (0 idle, 1 run, 2 drain)
    int          m_state;
    bit          m_level, m_tick, m_err, m_pend;
    int          m_left;
    logic [7:0]  m_div, m_pdiv;
    logic [15:0] m_edges;

    function automatic void model_reset();
        m_state = 0; m_level = 0; m_tick = 0; m_err = 0; m_pend = 0;
        m_left = 0; m_div = 8'd4; m_pdiv = 8'd0; m_edges = 16'd0;
    endfunction

    function automatic void model_step();
        bit fire, falling, apply, old_level;
        logic [7:0] nd;
        fire      = cfg_valid && !m_pend;
        falling   = (m_state != 0) && m_level && (m_left == 1);
        apply     = m_pend && ((m_state == 0) || falling);
        nd        = apply ? m_pdiv : m_div;
        if (m_tick) m_edges = m_edges + 16'd1;
        m_err     = fire && (cfg_div == 8'd0);
        m_tick    = 0;
        old_level = m_level;
        if (m_state == 0) begin
            m_level = 0;
            if (run) begin
                m_state = 1;
                m_left  = nd;
            end
        end else if (m_state == 1 && !run && !old_level) begin
            m_state = 0;
        end else begin
            if (m_left == 1) begin
                m_level = !m_level;
                m_left  = nd;
                m_tick  = m_level;
            end else begin
                m_left--;
            end
            if (m_state == 1 && !run)        m_state = falling ? 0 : 2;
            else if (m_state == 2 && falling) m_state = 0;
        end
        if (apply) begin
            m_div  = m_pdiv;
            m_pend = 0;
        end
        if (fire && cfg_div != 8'd0) begin
            m_pend = 1;
            m_pdiv = cfg_div;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_clk_div",   clk_div,    m_level);
            check("m_div_tick",  div_tick,   m_tick);
            check("m_cfg_err",   cfg_err,    m_err);
            check("m_cfg_ready", cfg_ready,  !m_pend);
            check("m_busy",      busy,       m_state != 0);
            check("m_active",    active_div, m_div);
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
            check("m_edge_cnt",  edge_cnt,   m_edges);
`else
            check("m_edge_cnt",  edge_cnt,   16'd0);
`endif
        end
    end

    // Counts consecutive sampled cycles with clk_div == val, starting at the current negedge.
    task automatic count_run(input logic val, output int n);
        n = 0;
        while (clk_div == val && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_tick4();
        int k = 0;
        while (!(div_tick && active_div == 8'd4) && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("wait_tick4", div_tick && active_div == 8'd4, 1'b1);
    endtask

    initial begin
        int n;
        logic [15:0] e0, diff;
        model_reset();
        rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        repeat (3) @(negedge clk);
        started = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("rst_clk_div", clk_div, 1'b0);
        check("rst_tick",    div_tick, 1'b0);
        check("rst_busy",    busy, 1'b0);
        check("rst_ready",   cfg_ready, 1'b1);
        check("rst_err",     cfg_err, 1'b0);
        check("rst_active",  active_div, 8'd4);
        check("rst_edges",   edge_cnt, 16'd0);

        // Default ratio: one idle cycle plus 4 RUN cycles low, then 4 high / 4 low
        run = 1'b1;
        count_run(1'b0, n); check("start_low", n, 5);
        count_run(1'b1, n); check("dflt_high", n, 4);
        count_run(1'b0, n); check("dflt_low",  n, 4);
        check("dflt_tick", div_tick, 1'b1);
        e0 = edge_cnt;
        repeat (80) @(negedge clk);
        diff = edge_cnt - e0;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        check("edges_10", diff, 16'd10);
`else
        check("edges_off", edge_cnt, 16'd0);
`endif
        check("tick_again", div_tick, 1'b1);

        // Ratio change accepted in the first high cycle
        cfg_valid = 1'b1; cfg_div = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("chg_pending", cfg_ready, 1'b0);
        check("chg_old_div", active_div, 8'd4);
        count_run(1'b1, n); check("chg_high_rest", n, 3);
        check("chg_applied", active_div, 8'd2);
        check("chg_ready",   cfg_ready, 1'b1);
        count_run(1'b0, n); check("new_low",  n, 2);
        count_run(1'b1, n); check("new_high", n, 2);

        // Zero ratio
        cfg_valid = 1'b1; cfg_div = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("zero_err",    cfg_err, 1'b1);
        check("zero_ready",  cfg_ready, 1'b1);
        check("zero_active", active_div, 8'd2);
        @(negedge clk);
        check("zero_err_end", cfg_err, 1'b0);

        // Stop during high phase cycle 1 at ratio 4
        cfg_valid = 1'b1; cfg_div = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_tick4();
        run = 1'b0;
        count_run(1'b1, n); check("drain_high", n, 4);
        check("stop_busy", busy, 1'b0);
        check("stop_low",  clk_div, 1'b0);

        // Asynchronous reset with a pending ratio
        run = 1'b1;
        wait_tick4();
        cfg_valid = 1'b1; cfg_div = 8'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("rr_pending", cfg_ready, 1'b0);
        check("rr_high",    clk_div, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rr_clk_div", clk_div, 1'b0);
        check("rr_busy",    busy, 1'b0);
        check("rr_ready",   cfg_ready, 1'b1);
        check("rr_active",  active_div, 8'd4);
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        check("rr_discard", active_div, 8'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) run = ~run;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the team's clock-divide function. It owns a programmable divided-clock generator and sequences it through start, stop and ratio changes. Changes take effect only at period boundaries, so `clk_div` never carries a shortened high pulse. It sits between the register/config side, which issues ratio requests over a valid/ready handshake, and the logic clocked or enabled by `clk_div` / `div_tick`.

## Interface
- `DIV_W`, 8: width of the half-period ratio.
- `DEFAULT_DIV`, 4: half-period ratio loaded at reset. Must be nonzero; 4 gives divide-by-8.
- `clk` in 1: single system clock. All logic is on `posedge clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level request to run the divider.
- `cfg_valid` in 1: a ratio request is presented.
- `cfg_div` in `DIV_W`: requested half-period ratio, in `clk` cycles.
- `cfg_ready` out 1: the block can accept a request.
- `cfg_err` out 1: one-cycle pulse when a zero ratio is rejected.
- `clk_div` out 1: divided clock, registered, period `2*active_div`.
- `div_tick` out 1: one-cycle pulse in the first cycle `clk_div` is high.
- `busy` out 1: state is not IDLE.
- `active_div` out `DIV_W`: ratio currently in effect.
- `edge_cnt` out 16: count of `clk_div` rising edges (see Configuration).

## Operation
- **Reset values:** state IDLE, `clk_div`=0, `div_tick`=0, `busy`=0, `cfg_ready`=1, `cfg_err`=0, `active_div`=`DEFAULT_DIV`, internal `cnt`=0, pending flag cleared, `edge_cnt`=0.
- **Handshake:** a transfer happens when `cfg_valid & cfg_ready` at a clock edge.
  - `cfg_div`=0: request is consumed but rejected. `cfg_err` pulses the next cycle; nothing else changes.
  - Nonzero: value is stored as pending. `cfg_ready` goes low until the pending value is applied.
- **Applying a pending ratio:**
  - IDLE: applied the cycle after acceptance.
  - RUN/DRAIN: applied on the same edge on which `clk_div` falls, i.e. the period boundary.
  - A value accepted on a boundary edge waits for the next boundary.
  - `cnt` is cleared on every apply.
- **States:**
  - IDLE: `clk_div`=0, `cnt` held at 0. `run`=1 leads to RUN.
  - RUN: `cnt` counts 0..`active_div`-1. At `active_div`-1, `clk_div` toggles and `cnt` returns to 0.
    - `run`=0 while `clk_div`=0 leads to IDLE next cycle. Truncating the low phase is allowed.
    - `run`=0 while `clk_div`=1 leads to DRAIN.
  - DRAIN: completes the current high phase, then `clk_div` falls and the state goes to IDLE. `run` is ignored in DRAIN.
- **Width rules:**
  - `cnt` is `DIV_W` bits. `active_div`=1 gives divide-by-2.
  - `edge_cnt` wraps from 0xFFFF to 0.

## Timing
- **Start:** `run` sampled high in IDLE at edge N puts the block in RUN with `cnt`=0 after N. `clk_div` and `div_tick` go high after edge N+`active_div`.
- **Steady state:** high and low phases are each exactly `active_div` cycles. `div_tick` is high for one cycle per period, aligned to the rising edge of `clk_div`.
- **Ratio change mid-run:** the old ratio completes the current high phase. The new ratio governs from the next low phase.
- **Stop:** latency to IDLE is 1 cycle from the low phase, or the remainder of the high phase plus 1 cycle from the high phase.
- **Reset mid-operation:** `rst_n` low immediately forces all reset values, asynchronously. Any pending ratio is discarded.

## Configuration
- Macro: `CLK_DIV_CTRL_EDGE_CNT_EN`.
- **Defined:** `edge_cnt` increments once per `div_tick`, wraps at 16 bits, and is cleared only by reset.
- **Undefined:** the counter is not built and `edge_cnt` is tied to 0. The port list is identical in both builds.

## Structure
- **Shared package:** the state enum (IDLE, RUN, DRAIN), the constant `EDGE_CNT_W`=16, and a `DIV_ZERO` error code constant.
- **Sub-module:** `clk_div_core`, the counter/toggle generator. It takes `active_div`, `enable` and a `stop_at_low` request, and returns `clk_div`, `div_tick` and a `boundary` strobe.
- **Top level:** the FSM, the config handshake and pending register, and `edge_cnt`.

## Test plan
- **Reset:** release `rst_n` with `run`=0 → all outputs at reset values, `active_div`=4, `cfg_ready`=1.
- **Default ratio:** `run`=1 → first `clk_div` rise 4 cycles after entering RUN, then period 8 (4 high, 4 low), one `div_tick` per period; with the macro defined, `edge_cnt`=10 after 10 periods.
- **Mid-run ratio change:** `cfg_div`=2 accepted during a high phase → high phase stays 4 cycles, `active_div`=2 from the falling edge, following phases 2 cycles, `cfg_ready` back to 1 at the apply edge.
- **Zero ratio:** `cfg_div`=0 → `cfg_err` pulses 1 cycle, `active_div` unchanged, `cfg_ready` stays 1.
- **Stop in high phase:** drop `run` on high-phase cycle 1 of 4 → DRAIN, full 4-cycle high phase, `clk_div` falls, IDLE next, `busy`=0.
- **Reset mid-run:** assert `rst_n` low mid-run with a pending ratio → `clk_div`=0 asynchronously, pending value discarded, `active_div`=4 after release.
